axi_mm_mem_burst: RTL and testbench
===================================

AXI_MM_MEM_BURST -- requirements
Module: axi_mm_mem_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_BITS, default 8, word-address width; depth DEPTH = 2^ADDR_BITS words.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  burst command valid.
REQ-006 SHALL have port cmd_ready  output  1  block accepts a command.
REQ-007 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_addr  input  ADDR_BITS  start word address.
REQ-009 SHALL have port cmd_len  input  8  beats minus one.
REQ-010 SHALL have port cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 SHALL have ports wvalid/wready  input/output  1  write-beat handshake, plus wdata  input  DATA_WIDTH and wstrb  input  DATA_WIDTH/8.
REQ-012 SHALL have ports rvalid/rready  output/input  1  read-beat handshake, plus rdata  output  DATA_WIDTH and rlast  output  1.
REQ-013 SHALL have port done  output  1  one-cycle pulse at burst completion; port err  output  1  sticky command-error flag.

Function
REQ-014 SHALL use FSM states IDLE, WRITE, READ (plus INIT, REQ-029); cmd_ready = 1 only in IDLE.
REQ-015 SHALL latch cmd_* on cmd_valid&cmd_ready and enter WRITE or READ the next cycle; beat counter loads cmd_len.
REQ-016 SHALL compute the next address per beat: FIXED unchanged; INCR +1 modulo DEPTH; WRAP +1 within a 2-,4-,8- or 16-word aligned window of size cmd_len+1.
REQ-017 SHALL set err and treat the burst as INCR when cmd_burst = 11, or WRAP with cmd_len not in {1,3,7,15}; err clears only on reset.
REQ-018 SHALL, in WRITE, hold wready = 1; on each wvalid&wready update the addressed word bytes whose wstrb bit is 1, others unchanged.
REQ-019 SHALL leave WRITE for IDLE on the final beat handshake, asserting done in the following cycle.
REQ-020 SHALL, in READ, register memory data with 1-cycle latency; next read issued when rvalid = 0 or rvalid&rready, sustaining 1 beat/cycle under rready = 1.
REQ-021 SHALL hold rdata, rlast and rvalid stable while rvalid=1 and rready=0.
REQ-022 SHALL assert rlast on the final beat only; leave READ on its handshake, done the next cycle.
REQ-023 SHALL ignore wvalid outside WRITE (wready = 0) and keep rvalid = 0 outside READ except for the in-flight final beat.
REQ-024 SHALL, for cmd_len = 0, transfer exactly one beat; for cmd_len = 255, 256 beats with INCR wrapping DEPTH-1 -> 0.

Reset
REQ-025 SHALL on rst_n = 0 drive cmd_ready = 0 (1 from the first cycle after release unless INIT), wready 0, rvalid 0, rdata 0, rlast 0, done 0, err 0, FSM IDLE.
REQ-026 SHALL abort any burst in progress on reset with no further memory writes; contents otherwise retained.
REQ-027 SHALL accept no command during the reset cycle.

Configuration
REQ-028 SHALL, without AXI_MM_MEM_RST_CLEAR_EN, leave memory contents undefined after power-up and untouched by reset.
REQ-029 SHALL, with AXI_MM_MEM_RST_CLEAR_EN defined, enter INIT after reset, write 0 to addresses 0..DEPTH-1 one per cycle with cmd_ready = 0, then go to IDLE; reset during INIT restarts it at 0.

Verification
REQ-030 SHALL cover: INCR write addr 0x10 len 3 data 1..4, INCR read same -> rdata 1,2,3,4, rlast on 4th, done once each.
REQ-031 SHALL cover: write 0xAABBCCDD then wstrb 0010 data 0x00001100 -> readback 0xAABB11DD.
REQ-032 SHALL cover: WRAP read addr 0x0E len 3 -> addresses 0x0E,0x0F,0x0C,0x0D; WRAP len 2 -> err = 1, INCR order.
REQ-033 SHALL cover: 8-beat read with rready toggling 1,0,0,1 -> no lost or duplicated beat, rdata held during stall.
REQ-034 SHALL cover: INCR write addr 0xFE len 3 -> words 0xFE,0xFF,0x00,0x01; reset asserted mid-burst -> wready 0, subsequent beats not written.
REQ-035 SHALL cover: with AXI_MM_MEM_RST_CLEAR_EN, cmd_ready low for DEPTH cycles after reset, then any read returns 0.

Source files
------------

// File: rtl/axi_mm_mem_burst.sv
// Burst-command word memory with FIXED/INCR/WRAP write and read beat channels.
// Define AXI_MM_MEM_RST_CLEAR_EN to zero the whole memory (INIT state) after every reset.
module axi_mm_mem_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [1:0]              cmd_burst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rlast,
    output logic                    done,
    output logic                    err
);
    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, READ, INIT} state_t;

`ifdef AXI_MM_MEM_RST_CLEAR_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            burst_q, burst_d;
    logic [ADDR_BITS-1:0]  mask_q, mask_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [ADDR_BITS-1:0]  addr_next;
    logic                  wrap_len_ok;
    logic                  cmd_err;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_W-1:0]     mem_wbe;

    // WRAP keeps the upper address bits and lets only the low window bits count
    always_comb begin
        addr_next = addr_q + 1'b1;
        case (burst_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~mask_q) | ((addr_q + 1'b1) & mask_q);
            default:     addr_next = addr_q + 1'b1;
        endcase
    end

    always_comb begin
        wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                      (cmd_len == 8'd7) || (cmd_len == 8'd15);
        cmd_err     = (cmd_burst == 2'b11) || ((cmd_burst == BURST_WRAP) && !wrap_len_ok);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        mask_d    = mask_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata;
        mem_wbe   = wstrb;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    burst_d = cmd_err ? BURST_INCR : cmd_burst;
                    mask_d  = ADDR_BITS'(cmd_len[3:0]);
                    err_d   = err_q | cmd_err;
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wvalid && wready_q) begin
                    mem_we = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            READ: begin
                // The output register is the only beat buffer: refill it when empty or draining
                if (rvalid_q && rready && rlast_q) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end else if (!rvalid_q || rready) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem[addr_q];
                    rlast_d  = (cnt_q == 8'd0);
                    if (cnt_q != 8'd0) begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
`ifdef AXI_MM_MEM_RST_CLEAR_EN
            INIT: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                mem_wbe   = '1;
                if (addr_q == {ADDR_BITS{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        wready_d    = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            addr_q      <= '0;
            cnt_q       <= '0;
            burst_q     <= BURST_INCR;
            mask_q      <= '0;
            cmd_ready_q <= 1'b0;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            mask_q      <= mask_d;
            cmd_ready_q <= cmd_ready_d;
            wready_q    <= wready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Writes are gated by rst_n so a reset mid-burst cannot corrupt the array
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wready    = wready_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi_mm_mem_burst.sv
// Directed self-checking bench for axi_mm_mem_burst (default 32-bit x 256 words).
// Expected values are hand-computed; build with AXI_MM_MEM_RST_CLEAR_EN to cover the INIT clear.
module tb_axi_mm_mem_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rlast;
    logic        done;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    int          doneCount = 0;
    int          expDone = 0;
    logic [31:0] rd [256];
    logic        rl [256];
    logic [31:0] ex [256];

`ifdef AXI_MM_MEM_RST_CLEAR_EN
    localparam int EXP_READY_CYCLES = 256;
`else
    localparam int EXP_READY_CYCLES = 1;
`endif

    axi_mm_mem_burst #(.DATA_WIDTH(32), .ADDR_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendCmd(input logic wr, input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) checkOutput("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_burst = burst;
        tick();
        cmd_valid = 1'b0;
        checkOutput("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    endtask

    task automatic writeBurst(input int n, input logic [31:0] base, input logic [3:0] strb);
        for (int i = 0; i < n; i++) begin
            int c = 0;
            wvalid = 1'b1;
            wdata  = base + 32'(i);
            wstrb  = strb;
            while (wready !== 1'b1 && c < 20) begin
                tick();
                c++;
            end
            if (wready !== 1'b1) checkOutput("wready_timeout", {63'd0, wready}, 64'd1);
            tick();
        end
        wvalid = 1'b0;
        expDone++;
        checkOutput("write_done_pulse", {63'd0, done}, 64'd1);
        checkOutput("write_wready_low", {63'd0, wready}, 64'd0);
        tick();
        checkOutput("write_done_clear", {63'd0, done}, 64'd0);
    endtask

    task automatic readBurst(input string tag, input int n, input logic [3:0] pat);
        int          got = 0;
        int          cyc = 0;
        logic        prevStall = 1'b0;
        logic [31:0] prevData = '0;
        logic        prevLast = 1'b0;
        while (got < n && cyc < 200) begin
            rready = pat[3 - (cyc % 4)];
            if (prevStall) begin
                checkOutput({tag, "_rvalid_hold"}, {63'd0, rvalid}, 64'd1);
                checkOutput({tag, "_rdata_hold"}, {32'd0, rdata}, {32'd0, prevData});
                checkOutput({tag, "_rlast_hold"}, {63'd0, rlast}, {63'd0, prevLast});
            end
            if (rvalid === 1'b1 && rready === 1'b1) begin
                rd[got] = rdata;
                rl[got] = rlast;
                got++;
            end
            prevStall = (rvalid === 1'b1) && !rready;
            prevData  = rdata;
            prevLast  = rlast;
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (got < n) checkOutput({tag, "_read_timeout"}, 64'(got), 64'(n));
        expDone++;
        checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_rvalid_idle"}, {63'd0, rvalid}, 64'd0);
        for (int i = 0; i < got; i++) begin
            checkOutput($sformatf("%s_rdata[%0d]", tag, i), {32'd0, rd[i]}, {32'd0, ex[i]});
            checkOutput($sformatf("%s_rlast[%0d]", tag, i), {63'd0, rl[i]}, {63'd0, (i == n - 1)});
        end
        tick();
        checkOutput({tag, "_done_clear"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_burst = 2'b01; wvalid = 1'b0; wdata = '0; wstrb = '0; rready = 1'b0;
        tick(); tick(); tick();
        checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("rst_wready", {63'd0, wready}, 64'd0);
        checkOutput("rst_rvalid", {63'd0, rvalid}, 64'd0);
        checkOutput("rst_rdata", {32'd0, rdata}, 64'd0);
        checkOutput("rst_rlast", {63'd0, rlast}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (cmd_ready !== 1'b1 && n < 400);
        checkOutput("ready_after_reset_cycles", 64'(n), 64'(EXP_READY_CYCLES));

        // wvalid in IDLE is ignored
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        tick();
        checkOutput("idle_wready", {63'd0, wready}, 64'd0);
        wvalid = 1'b0;

        sendCmd(1'b1, 8'h10, 8'd3, 2'b01);
        writeBurst(4, 32'd1, 4'hF);
        sendCmd(1'b0, 8'h10, 8'd3, 2'b01);
        ex[0] = 32'd1; ex[1] = 32'd2; ex[2] = 32'd3; ex[3] = 32'd4;
        readBurst("incr", 4, 4'b1111);

        sendCmd(1'b1, 8'h30, 8'd0, 2'b01);
        writeBurst(1, 32'hAABB_CCDD, 4'hF);
        sendCmd(1'b1, 8'h30, 8'd0, 2'b01);
        writeBurst(1, 32'h0000_1100, 4'b0010);
        sendCmd(1'b0, 8'h30, 8'd0, 2'b01);
        ex[0] = 32'hAABB_11DD;
        readBurst("strb", 1, 4'b1111);

        sendCmd(1'b1, 8'h0C, 8'd3, 2'b01);
        writeBurst(4, 32'h0000_100C, 4'hF);
        sendCmd(1'b0, 8'h0E, 8'd3, 2'b10);
        ex[0] = 32'h100E; ex[1] = 32'h100F; ex[2] = 32'h100C; ex[3] = 32'h100D;
        readBurst("wrap4", 4, 4'b1111);
        checkOutput("wrap_ok_err", {63'd0, err}, 64'd0);
        sendCmd(1'b0, 8'h0D, 8'd2, 2'b10);
        ex[0] = 32'h100D; ex[1] = 32'h100E; ex[2] = 32'h100F;
        readBurst("wrap_bad", 3, 4'b1111);
        checkOutput("wrap_bad_err", {63'd0, err}, 64'd1);

        sendCmd(1'b1, 8'h20, 8'd7, 2'b01);
        writeBurst(8, 32'h0000_2000, 4'hF);
        sendCmd(1'b0, 8'h20, 8'd7, 2'b01);
        for (int i = 0; i < 8; i++) ex[i] = 32'h2000 + 32'(i);
        readBurst("stall", 8, 4'b1001);

        sendCmd(1'b1, 8'hFE, 8'd3, 2'b01);
        writeBurst(4, 32'h0000_5000, 4'hF);
        sendCmd(1'b0, 8'h00, 8'd1, 2'b01);
        ex[0] = 32'h5002; ex[1] = 32'h5003;
        readBurst("wrap_depth_low", 2, 4'b1111);
        sendCmd(1'b0, 8'hFE, 8'd3, 2'b01);
        ex[0] = 32'h5000; ex[1] = 32'h5001; ex[2] = 32'h5002; ex[3] = 32'h5003;
        readBurst("wrap_depth", 4, 4'b1111);

        sendCmd(1'b1, 8'h50, 8'd2, 2'b00);
        writeBurst(3, 32'h0000_000A, 4'hF);
        sendCmd(1'b0, 8'h50, 8'd0, 2'b01);
        ex[0] = 32'h0000_000C;
        readBurst("fixed", 1, 4'b1111);

        // Reset in the third beat of a write burst: beats 3 and 4 must not land
        sendCmd(1'b1, 8'h40, 8'd3, 2'b01);
        writeBurst(4, 32'h0000_7000, 4'hF);
        sendCmd(1'b1, 8'h40, 8'd3, 2'b01);
        checkOutput("abort_wready_pre", {63'd0, wready}, 64'd1);
        wvalid = 1'b1; wstrb = 4'hF; wdata = 32'h6000;
        tick();
        wdata = 32'h6001;
        tick();
        wdata = 32'h6002; rst_n = 1'b0;
        tick();
        checkOutput("abort_wready", {63'd0, wready}, 64'd0);
        checkOutput("abort_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("abort_err_cleared", {63'd0, err}, 64'd0);
        wdata = 32'h6003;
        tick();
        rst_n = 1'b1; wvalid = 1'b0;
        sendCmd(1'b0, 8'h40, 8'd3, 2'b01);
`ifdef AXI_MM_MEM_RST_CLEAR_EN
        ex[0] = 32'h0; ex[1] = 32'h0; ex[2] = 32'h0; ex[3] = 32'h0;
`else
        ex[0] = 32'h6000; ex[1] = 32'h6001; ex[2] = 32'h7002; ex[3] = 32'h7003;
`endif
        readBurst("abort", 4, 4'b1111);

`ifdef AXI_MM_MEM_RST_CLEAR_EN
        sendCmd(1'b0, 8'h90, 8'd0, 2'b01);
        ex[0] = 32'h0;
        readBurst("init_clear", 1, 4'b1111);
`endif

        tick();
        checkOutput("done_count", 64'(doneCount), 64'(expDone));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
